// File: rtl/eth_clk_pkg.sv
// Shared types and constants for the Ethernet TX clock path.
// Speed encodings, sequencer states and the GTX reset stretch length.
package eth_clk_pkg;

   typedef enum logic [1:0] {
      SPEED_10M   = 2'b00,
      SPEED_100M  = 2'b01,
      SPEED_1000M = 2'b10,
      SPEED_RSVD  = 2'b11
   } eth_speed_e;

   typedef enum logic [2:0] {
      ST_INIT   = 3'd0,
      ST_IDLE   = 3'd1,
      ST_DRAIN  = 3'd2,
      ST_RESET  = 3'd3,
      ST_SETTLE = 3'd4,
      ST_DONE   = 3'd5
   } eth_speed_seq_state_e;

   localparam int unsigned eth_gtx_rst_stretch_lp = 128;

   function automatic int unsigned max3(int unsigned a,
                                        int unsigned b,
                                        int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/eth_speed_seq_timer.sv
// Loadable down-counter with a zero flag, shared by all timed
// sequencer states. Saturates at zero.
module eth_speed_seq_timer #(
   parameter int unsigned       width_p     = 9,
   parameter logic [width_p-1:0] reset_val_p = '0
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               load_i,
   input  logic [width_p-1:0] load_val_i,
   output logic               zero_o
);

   logic [width_p-1:0] cnt_d, cnt_q;

   // next count: load, else decrement until zero
   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = load_val_i;
      else if (cnt_q != '0)
         cnt_d = cnt_q - 1'b1;
   end

   // count register
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) cnt_q <= reset_val_p;
      else         cnt_q <= cnt_d;
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/eth_tx_speed_change_sequencer.sv
// Sequences TX link-speed changes: drain, generator reset, settle.
// Optional drain timeout: ETH_SPEED_SEQ_DRAIN_TIMEOUT_EN.
module eth_tx_speed_change_sequencer
   import eth_clk_pkg::*;
#(
   parameter int unsigned reset_cycles_p   = 4,
   parameter int unsigned settle_cycles_p  = 256,
   parameter int unsigned timeout_cycles_p = 65535,
   parameter logic [1:0]  init_setting_p   = 2'b10
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       speed_v_i,
   input  logic [1:0] speed_i,
   output logic       speed_ready_o,
   output logic       tx_pause_o,
   input  logic       tx_idle_i,
   output logic [1:0] clk_setting_o,
   output logic       gen_reset_o,
   output logic       busy_o,
   output logic       done_o,
   output logic       error_o
);

   localparam int unsigned max_lp =
      max3(reset_cycles_p, settle_cycles_p, timeout_cycles_p);
   localparam int unsigned cnt_w_lp = $clog2(max_lp) + 1;
   localparam logic [cnt_w_lp-1:0] rst_ld_lp =
      cnt_w_lp'(reset_cycles_p - 1);
   localparam logic [cnt_w_lp-1:0] set_ld_lp =
      cnt_w_lp'(settle_cycles_p - 1);

   if (settle_cycles_p <= eth_gtx_rst_stretch_lp) begin : g_chk_settle
      $error("settle_cycles_p must exceed the GTX reset stretch");
   end
   if (reset_cycles_p < 1) begin : g_chk_reset
      $error("reset_cycles_p must be at least 1");
   end

   eth_speed_seq_state_e state_d, state_q;
   logic [1:0]          target_d, target_q;
   logic [1:0]          setting_d, setting_q;
   logic                gen_reset_d, gen_reset_q;
   logic                pause_d, pause_q;
   logic                ready_d, ready_q;
   logic                done_d, done_q;
   logic                error_d, error_q;
   logic                accept;
   logic                tmr_load;
   logic [cnt_w_lp-1:0] tmr_val;
   logic                tmr_zero;

   eth_speed_seq_timer #(
      .width_p     (cnt_w_lp),
      .reset_val_p (rst_ld_lp)
   ) u_timer (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .zero_o     (tmr_zero)
   );

   assign accept = speed_v_i & ready_q;

   // state transitions, target latch and timer reloads
   always_comb begin
      state_d   = state_q;
      target_d  = target_q;
      setting_d = setting_q;
      error_d   = 1'b0;
      tmr_load  = 1'b0;
      tmr_val   = '0;
      unique case (state_q)
         ST_INIT: begin
            if (tmr_zero) begin
               state_d  = ST_SETTLE;
               tmr_load = 1'b1;
               tmr_val  = set_ld_lp;
            end
         end
         ST_IDLE: begin
            if (accept) begin
               if (speed_i == SPEED_RSVD) begin
                  error_d = 1'b1;
               end else if (speed_i == setting_q) begin
                  state_d = ST_DONE;
               end else begin
                  state_d  = ST_DRAIN;
                  target_d = speed_i;
`ifdef ETH_SPEED_SEQ_DRAIN_TIMEOUT_EN
                  tmr_load = 1'b1;
                  tmr_val  = cnt_w_lp'(timeout_cycles_p);
`endif
               end
            end
         end
         ST_DRAIN: begin
            if (tx_idle_i) begin
               state_d   = ST_RESET;
               setting_d = target_q;
               tmr_load  = 1'b1;
               tmr_val   = rst_ld_lp;
            end
`ifdef ETH_SPEED_SEQ_DRAIN_TIMEOUT_EN
            else if (tmr_zero) begin
               state_d = ST_IDLE;
               error_d = 1'b1;
            end
`endif
         end
         ST_RESET: begin
            if (tmr_zero) begin
               state_d  = ST_SETTLE;
               tmr_load = 1'b1;
               tmr_val  = set_ld_lp;
            end
         end
         ST_SETTLE: begin
            if (tmr_zero) state_d = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_INIT;
      endcase
   end

   // registered outputs decoded from the next state
   always_comb begin
      gen_reset_d = (state_d == ST_INIT) || (state_d == ST_RESET);
      ready_d     = (state_d == ST_IDLE);
      done_d      = (state_d == ST_DONE);
      pause_d     = 1'b1;
      if (state_d == ST_IDLE)      pause_d = 1'b0;
      else if (state_d == ST_DONE) pause_d = pause_q;
   end

   // state and output registers
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q     <= ST_INIT;
         target_q    <= init_setting_p;
         setting_q   <= init_setting_p;
         gen_reset_q <= 1'b1;
         pause_q     <= 1'b1;
         ready_q     <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         target_q    <= target_d;
         setting_q   <= setting_d;
         gen_reset_q <= gen_reset_d;
         pause_q     <= pause_d;
         ready_q     <= ready_d;
         done_q      <= done_d;
         error_q     <= error_d;
      end
   end

   assign speed_ready_o = ready_q;
   assign busy_o        = ~ready_q;
   assign tx_pause_o    = pause_q;
   assign clk_setting_o = setting_q;
   assign gen_reset_o   = gen_reset_q;
   assign done_o        = done_q;
   assign error_o       = error_q;

endmodule
